// File: rtl/pcm_flash_pkg.sv
// Shared constants for the PCM flash reader: FSM encoding, SPI READ framing
// and the transfer-length helper used by the serial shifter.
package pcm_flash_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [7:0] FLASH_CMD_READ = 8'h03;

  localparam int CMD_BITS        = 32;
  localparam int DATA_BITS       = 8;
  localparam int MISO_SYNC_DELAY = 2;

  // Receive transfers run a little longer so the last bit can crawl through the MISO synchroniser.
  function automatic logic [6:0] xfer_cycles(input logic [5:0] bits, input logic capture);
    xfer_cycles = {bits, 1'b0} + (capture ? 7'(MISO_SYNC_DELAY) : 7'd0);
  endfunction

endpackage

// File: rtl/pcm_flash_spi_shifter.sv
// Mode-0 SPI bit engine: two clk cycles per bit, MSB-first transmit, MSB-first
// receive with sampling delayed one bit period behind SCK.
module pcm_flash_spi_shifter
  import pcm_flash_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        capture,
  input  logic [31:0] load,
  input  logic [5:0]  len,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic        done,
  output logic [7:0]  rx_byte
);

  logic        miso_meta;
  logic        miso_sync;
  logic        busy;
  logic        capture_r;
  logic [5:0]  len_r;
  logic [6:0]  cnt;
  logic [6:0]  total;
  logic [6:0]  next_cnt;
  logic [31:0] tx_sr;
  logic [6:0]  rx_sr;

  assign next_cnt = cnt + 7'd1;
  // The byte is complete on the edge that ends the done cycle, so expose the final shift directly.
  assign rx_byte  = {rx_sr, miso_sync};

  always_ff @(posedge clk) begin
    if (reset) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
      busy      <= 1'b0;
      capture_r <= 1'b0;
      len_r     <= '0;
      cnt       <= '0;
      total     <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      done      <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
      if (start) begin
        busy      <= 1'b1;
        capture_r <= capture;
        len_r     <= len;
        total     <= xfer_cycles(len, capture);
        cnt       <= '0;
        tx_sr     <= {load[30:0], 1'b0};
        mosi      <= load[31];
        sck       <= 1'b0;
        done      <= 1'b0;
      end else if (busy) begin
        cnt  <= next_cnt;
        busy <= (cnt != total - 7'd1);
        done <= (next_cnt == total - 7'd1);
        sck  <= (next_cnt < {len_r, 1'b0}) && !cnt[0];
        if (cnt[0] && (next_cnt < {len_r, 1'b0})) begin
          mosi  <= tx_sr[31];
          tx_sr <= {tx_sr[30:0], 1'b0};
        end
        // Sample at the end of each high phase, one bit period late.
        if (capture_r && cnt[0] && (cnt > 7'(MISO_SYNC_DELAY)))
          rx_sr <= {rx_sr[5:0], miso_sync};
      end
    end
  end

endmodule

// File: rtl/pcm_flash_reader.sv
// Serves byte reads from a single-bit SPI NOR flash, keeping CS low between
// requests so the next sequential byte only costs eight more SCK pulses.
module pcm_flash_reader
  import pcm_flash_pkg::*;
#(
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter int          HOLD_TIMEOUT = 64,
  parameter int          CS_HIGH_MIN  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pcm_mem_addr,
  input  logic        pcm_mem_valid,
  output logic [7:0]  pcm_mem_rdata,
  output logic        pcm_mem_ready,
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  logic [2:0]  state;
  logic [23:0] addr;
  logic [23:0] next_addr;
  logic [23:0] flash_addr;
  logic [3:0]  cs_high_cnt;
  logic [7:0]  hold_cnt;
  logic        cold_accept;
  logic        seq_hit;
  logic        sh_start;
  logic        sh_capture;
  logic        sh_done;
  logic [31:0] sh_load;
  logic [5:0]  sh_len;
  logic [7:0]  rx_byte;

  assign flash_addr  = pcm_mem_addr + FLASH_OFFSET;
  assign cold_accept = (state == S_IDLE) && pcm_mem_valid && (cs_high_cnt >= 4'(CS_HIGH_MIN));
  assign seq_hit     = (state == S_HOLD) && pcm_mem_valid && (pcm_mem_addr == next_addr);
  assign sh_start    = cold_accept || seq_hit || ((state == S_CMD) && sh_done);
  assign sh_capture  = !cold_accept;
  assign sh_load     = cold_accept ? {FLASH_CMD_READ, flash_addr} : 32'd0;
  assign sh_len      = cold_accept ? 6'(CMD_BITS) : 6'(DATA_BITS);

  pcm_flash_spi_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .start   (sh_start),
    .capture (sh_capture),
    .load    (sh_load),
    .len     (sh_len),
    .miso    (spi_miso),
    .sck     (spi_sck),
    .mosi    (spi_mosi),
    .done    (sh_done),
    .rx_byte (rx_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      addr          <= '0;
      next_addr     <= '0;
      cs_high_cnt   <= 4'(CS_HIGH_MIN);
      hold_cnt      <= '0;
      spi_cs_n      <= 1'b1;
      pcm_mem_ready <= 1'b0;
      pcm_mem_rdata <= '0;
    end else begin
      pcm_mem_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          spi_cs_n <= 1'b1;
          if (cs_high_cnt < 4'(CS_HIGH_MIN))
            cs_high_cnt <= cs_high_cnt + 4'd1;
          if (cold_accept) begin
            addr     <= pcm_mem_addr;
            spi_cs_n <= 1'b0;
            state    <= S_CMD;
          end
        end
        S_CMD: begin
          if (sh_done)
            state <= S_DATA;
        end
        S_DATA: begin
          if (sh_done) begin
            pcm_mem_rdata <= rx_byte;
            pcm_mem_ready <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          next_addr <= addr + 24'd1;
          hold_cnt  <= '0;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          // A mismatching request leaves valid pending; IDLE picks it up once CS has been high long enough.
          if (seq_hit) begin
            addr  <= pcm_mem_addr;
            state <= S_DATA;
          end else if (pcm_mem_valid || (hold_cnt == 8'(HOLD_TIMEOUT - 1))) begin
            spi_cs_n    <= 1'b1;
            cs_high_cnt <= 4'd1;
            state       <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
